// File: rtl/fetch_stack_unit_pkg.sv
// Shared definitions for the fetch/return-stack slice: instruction field
// positions, the return opcode and the packed return-stack entry.
package fetch_stack_unit_pkg;

    localparam logic [4:0] RET_OPCODE = 5'b10101;

    // Instruction word field positions
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 11;
    localparam int unsigned TGT_HI = 10;
    localparam int unsigned TGT_LO = 2;

    // Entry PC field matches the jump-target field width
    localparam int unsigned ENTRY_PC_W = TGT_HI - TGT_LO + 1;
    localparam int unsigned FLAGS_W    = 4;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [FLAGS_W-1:0]    flags;
    } stack_entry_t;

endpackage

// File: rtl/fetch_stack_unit_return_stack.sv
// Return stack: DEPTH entries, sp counts occupied entries (0..DEPTH).
// Push+pop together overwrites the top (plain push when empty); push while
// full and pop while empty are ignored. Entry storage is not reset.
module return_stack
    import fetch_stack_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  stack_entry_t               i_entry,
    output stack_entry_t               o_top,
    output logic [$clog2(DEPTH):0]     o_sp
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   r_sp;
    stack_entry_t  r_mem [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_overwrite;
    logic          w_push_new;
    logic          w_pop_top;
    logic [AW-1:0] w_top_idx;
    logic [AW-1:0] w_wr_idx;

    // Decode the stack operation for this cycle
    always_comb begin
        w_full      = (r_sp == (AW+1)'(DEPTH));
        w_empty     = (r_sp == '0);
        w_overwrite = i_push && i_pop && !w_empty;
        w_push_new  = i_push && !w_overwrite && !w_full;
        w_pop_top   = i_pop && !i_push && !w_empty;
        w_top_idx   = AW'(r_sp - 1'b1);
        w_wr_idx    = w_overwrite ? w_top_idx : AW'(r_sp);
        o_top       = r_mem[w_top_idx];
        o_sp        = r_sp;
    end

    // Entry storage write (no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_overwrite || w_push_new)
            r_mem[w_wr_idx] <= i_entry;
    end

    // Stack pointer update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_sp <= '0;
        else if (w_push_new)
            r_sp <= r_sp + 1'b1;
        else if (w_pop_top)
            r_sp <= r_sp - 1'b1;
    end

endmodule

// File: rtl/fetch_stack_unit.sv
// Fetch unit: instruction register, program counter and return stack.
// Optional status outputs (stack_full, stack_empty, sticky stack_err) are
// enabled by defining STACK_STATUS_EN.
module fetch_stack_unit
    import fetch_stack_unit_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned PC_W        = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ir_load,
    input  logic [15:0]     ir_in,
    output logic [15:0]     ir_out,
    input  logic            pc_load,
    input  logic            pc_inc,
    input  logic            pc_en_out,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_bus,
    input  logic            push_en,
    input  logic            pop_en,
    input  logic [3:0]      flags_in,
    output logic [PC_W-1:0] stack_pc,
    output logic [3:0]      stack_flags
`ifdef STACK_STATUS_EN
    ,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            stack_err
`endif
);

    localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;

    logic [15:0]     r_ir;
    logic [PC_W-1:0] r_pc;

    logic            w_ret;
    logic            w_empty;
    logic [PC_W-1:0] w_pc_src;
    logic [SPW-1:0]  w_sp;
    stack_entry_t    w_wr_entry;
    stack_entry_t    w_top;

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (push_en),
        .i_pop   (pop_en),
        .i_entry (w_wr_entry),
        .o_top   (w_top),
        .o_sp    (w_sp)
    );

    // PC source select, stack write data and output views
    always_comb begin
        w_ret            = (r_ir[OPC_HI:OPC_LO] == RET_OPCODE);
        w_empty          = (w_sp == '0);
        stack_pc         = w_empty ? '0 : PC_W'(w_top.pc);
        stack_flags      = w_empty ? '0 : w_top.flags;
        w_pc_src         = w_ret ? stack_pc : PC_W'(r_ir[TGT_HI:TGT_LO]);
        w_wr_entry.pc    = ENTRY_PC_W'(r_pc);
        w_wr_entry.flags = flags_in;
        ir_out           = r_ir;
        pc_out           = r_pc;
        pc_bus           = pc_en_out ? r_pc : '0;
    end

    // Instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ir <= '0;
        else if (ir_load)
            r_ir <= ir_in;
    end

    // Program counter: load beats increment, increment wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= '0;
        else if (pc_load)
            r_pc <= w_pc_src;
        else if (pc_inc)
            r_pc <= r_pc + 1'b1;
    end

`ifdef STACK_STATUS_EN
    logic r_err;

    // Status flags from the stack pointer
    always_comb begin
        stack_full  = (w_sp == SPW'(STACK_DEPTH));
        stack_empty = w_empty;
        stack_err   = r_err;
    end

    // Sticky error: push while full or pop while empty, cleared by reset only
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if ((push_en && !pop_en && stack_full) ||
                 (pop_en && !push_en && w_empty))
            r_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_stack_unit.sv
// Self-checking bench for fetch_stack_unit: directed steps followed by a
// randomized run, all checked against a queue-based reference model.
module tb_fetch_stack_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_load;
    logic [15:0] ir_in;
    logic [15:0] ir_out;
    logic        pc_load;
    logic        pc_inc;
    logic        pc_en_out;
    logic [8:0]  pc_out;
    logic [8:0]  pc_bus;
    logic        push_en;
    logic        pop_en;
    logic [3:0]  flags_in;
    logic [8:0]  stack_pc;
    logic [3:0]  stack_flags;
`ifdef STACK_STATUS_EN
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;
`endif

    always #5 clk = ~clk;

    fetch_stack_unit #(
        .STACK_DEPTH (DEPTH),
        .PC_W        (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ir_load     (ir_load),
        .ir_in       (ir_in),
        .ir_out      (ir_out),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .pc_en_out   (pc_en_out),
        .pc_out      (pc_out),
        .pc_bus      (pc_bus),
        .push_en     (push_en),
        .pop_en      (pop_en),
        .flags_in    (flags_in),
        .stack_pc    (stack_pc),
        .stack_flags (stack_flags)
`ifdef STACK_STATUS_EN
        ,
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: entries stored as pc*16 + flags
    int m_ir;
    int m_pc;
    int m_q[$];
    int m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_top();
        return (m_q.size() > 0) ? m_q[m_q.size()-1] : 0;
    endfunction

    task automatic m_reset();
        m_ir  = 0;
        m_pc  = 0;
        m_err = 0;
        m_q.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ir"},     32'(ir_out),      32'(m_ir));
        chk({tag, ".pc"},     32'(pc_out),      32'(m_pc));
        chk({tag, ".spc"},    32'(stack_pc),    32'(m_top() / 16));
        chk({tag, ".sflg"},   32'(stack_flags), 32'(m_top() % 16));
        chk({tag, ".pcbus"},  32'(pc_bus),      pc_en_out ? 32'(m_pc) : 32'd0);
`ifdef STACK_STATUS_EN
        chk({tag, ".full"},   32'(stack_full),  32'(m_q.size() == DEPTH));
        chk({tag, ".empty"},  32'(stack_empty), 32'(m_q.size() == 0));
        chk({tag, ".err"},    32'(stack_err),   32'(m_err));
`endif
    endtask

    // One clock of stimulus: drive at negedge, advance model, check after edge
    task automatic step(input string tag, input logic il, input logic [15:0] iin,
                        input logic pl, input logic pi, input logic pe,
                        input logic pu, input logic po, input logic [3:0] fl);
        int src, entry, nxt_pc;
        @(negedge clk);
        ir_load = il; ir_in = iin; pc_load = pl; pc_inc = pi;
        pc_en_out = pe; push_en = pu; pop_en = po; flags_in = fl;
        src    = ((m_ir >> 11) == 'b10101) ? (m_top() / 16) : ((m_ir >> 2) & 'h1FF);
        nxt_pc = pl ? src : (pi ? (m_pc + 1) % 512 : m_pc);
        entry  = m_pc * 16 + int'(fl);
        if (pu && po) begin
            if (m_q.size() == 0) m_q.push_back(entry);
            else m_q[m_q.size()-1] = entry;
        end else if (pu) begin
            if (m_q.size() < DEPTH) m_q.push_back(entry);
            else m_err = 1;
        end else if (po) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_err = 1;
        end
        m_pc = nxt_pc;
        if (il) m_ir = int'(iin);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ir_load = 0; ir_in = '0; pc_load = 0; pc_inc = 0;
        pc_en_out = 0; push_en = 0; pop_en = 0; flags_in = '0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // First edge after reset acts normally; load and increment
        step("ld_ir",   1, 16'h8014, 0, 0, 1, 0, 0, 4'h0);
        step("ld_pc",   0, 16'h0000, 1, 0, 1, 0, 0, 4'h0);
        chk("pc_is5", 32'(pc_out), 32'd5);
        step("inc1",    0, 16'h0000, 0, 1, 0, 0, 0, 4'h0);
        step("inc2",    0, 16'h0000, 0, 1, 1, 0, 0, 4'h0);
        step("inc3",    0, 16'h0000, 0, 1, 1, 0, 0, 4'h0);
        chk("pc_is8", 32'(pc_out), 32'd8);
        step("ld_wins", 0, 16'h0000, 1, 1, 1, 0, 0, 4'h0);
        chk("pc_ldwin", 32'(pc_out), 32'd5);
        step("ir511",   1, 16'h07FC, 0, 0, 0, 0, 0, 4'h0);
        step("pc511",   0, 16'h0000, 1, 0, 1, 0, 0, 4'h0);
        step("wrap",    0, 16'h0000, 0, 1, 1, 0, 0, 4'h0);
        chk("pc_wrap", 32'(pc_out), 32'd0);

        // Call then return
        step("ir12",    1, 16'h0030, 0, 0, 0, 0, 0, 4'h0);
        step("pc12",    0, 16'h0000, 1, 0, 0, 0, 0, 4'h0);
        step("ir40",    1, 16'h00A0, 0, 0, 0, 0, 0, 4'h0);
        step("call",    0, 16'h0000, 1, 0, 1, 1, 0, 4'b0101);
        chk("call_pc",  32'(pc_out),      32'd40);
        chk("call_spc", 32'(stack_pc),    32'd12);
        chk("call_flg", 32'(stack_flags), 32'd5);
        step("ir_ret",  1, 16'hA800, 0, 0, 0, 0, 0, 4'h0);
        step("ret",     0, 16'h0000, 1, 0, 1, 0, 1, 4'h0);
        chk("ret_pc",   32'(pc_out),   32'd12);
        chk("ret_spc",  32'(stack_pc), 32'd0);

        // Nesting: pushes of PCs 1,2,3 then pops in reverse
        step("ir1",     1, 16'h0004, 0, 0, 0, 0, 0, 4'h0);
        step("pc1",     0, 16'h0000, 1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) step("nest_push", 0, 16'h0, 0, 1, 0, 1, 0, 4'(i));
        for (int i = 3; i >= 1; i--) begin
            chk("nest_top", 32'(stack_pc), 32'(i));
            step("nest_pop", 0, 16'h0, 0, 0, 0, 0, 1, 4'h0);
        end

        // Overflow: nine pushes, ninth ignored
        for (int i = 0; i < 9; i++) step("fill", 0, 16'h0, 0, 1, 0, 1, 0, 4'(i + 3));
        chk("full_top", 32'(stack_flags), 32'd10);
        for (int i = 0; i < 9; i++) step("drain", 0, 16'h0, 0, 0, 0, 0, 1, 4'h0);
        step("pop_empty", 0, 16'h0, 0, 0, 0, 0, 1, 4'h0);

        // Push+pop overwrite with top=7, pc=20
        step("ir7",     1, 16'h001C, 0, 0, 0, 0, 0, 4'h0);
        step("pc7",     0, 16'h0000, 1, 0, 0, 0, 0, 4'h0);
        step("push7",   0, 16'h0000, 0, 0, 0, 1, 0, 4'h1);
        step("ir20",    1, 16'h0050, 0, 0, 0, 0, 0, 4'h0);
        step("pc20",    0, 16'h0000, 1, 0, 0, 0, 0, 4'h0);
        step("pushpop", 0, 16'h0000, 0, 0, 0, 1, 1, 4'h2);
        chk("pp_top",   32'(stack_pc), 32'd20);
        chk("pp_depth", 32'(m_q.size()), 32'd1);
        step("pp_pop",  0, 16'h0000, 0, 0, 0, 0, 1, 4'h0);
        chk("pp_empty", 32'(stack_pc), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:11] = 5'b10101;
            step("rand", 1'($urandom_range(0, 3) == 0), w,
                 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 4'($urandom));
        end

        // Asynchronous reset mid-run, checked before any clock edge
        step("pre_rst", 1, 16'h1234, 1, 0, 1, 1, 0, 4'h9);
        @(posedge clk);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("arst_ir",  32'(ir_out),   32'd0);
        chk("arst_pc",  32'(pc_out),   32'd0);
        chk("arst_spc", 32'(stack_pc), 32'd0);
        @(negedge clk);
        check_all("in_rst");
        rst = 1'b0;
        step("post_rst", 1, 16'h0020, 0, 1, 1, 1, 0, 4'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
